// File: rtl/pac_ctrl.sv
// Pac-Man sprite controller: buttons, frame-rate divider, wall-aware stepping, sprite scan window.
// Optional macro PAC_TUNNEL_EN: horizontal moves wrap at the screen edges instead of saturating.
module pac_ctrl #(
    parameter int X_START = 304,
    parameter int Y_START = 336,
    parameter int X_MAX   = 616,
    parameter int Y_MAX   = 456,
    parameter int SPEED   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_l,
    input  logic       btn_u,
    input  logic       btn_r,
    input  logic       btn_d,
    input  logic       frame_tick,
    input  logic       blk_l,
    input  logic       blk_u,
    input  logic       blk_r,
    input  logic       blk_d,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic [9:0] pac_x,
    output logic [9:0] pac_y,
    output logic [3:0] direction,
    output logic [4:0] spr_x,
    output logic [4:0] spr_y,
    output logic       spr_en,
    output logic       moving
);

    localparam logic [3:0] DIR_L    = 4'b1000;
    localparam logic [3:0] DIR_U    = 4'b0100;
    localparam logic [3:0] DIR_R    = 4'b0010;
    localparam logic [3:0] DIR_D    = 4'b0001;
    localparam logic [3:0] DIV_LAST = 4'(SPEED - 1);
    localparam logic [9:0] XMAX_V   = 10'(X_MAX);
    localparam logic [9:0] YMAX_V   = 10'(Y_MAX);
    localparam logic [9:0] XSTART_V = 10'(X_START);
    localparam logic [9:0] YSTART_V = 10'(Y_START);

    logic [3:0]  req;
    logic [3:0]  div;
    logic [3:0]  btn;
    logic [3:0]  blk;
    logic [3:0]  btn_pri;
    logic        step;
    logic        req_open;
    logic        dir_open;
    logic [3:0]  mv_dir;
    logic        mv_ok;
    logic [9:0]  nx;
    logic [9:0]  ny;
    logic [10:0] x_end;
    logic [10:0] y_end;
    logic        in_win;
    logic [9:0]  off_x;
    logic [9:0]  off_y;

    assign btn = {btn_l, btn_u, btn_r, btn_d};
    assign blk = {blk_l, blk_u, blk_r, blk_d};

    always_comb begin
        if (btn_l)      btn_pri = DIR_L;
        else if (btn_u) btn_pri = DIR_U;
        else if (btn_r) btn_pri = DIR_R;
        else            btn_pri = DIR_D;
    end

    // req and direction are always one-hot, so a single AND tells whether the heading hits a wall
    assign step     = frame_tick && (div == DIV_LAST);
    assign req_open = ~|(req & blk);
    assign dir_open = ~|(direction & blk);
    assign mv_dir   = req_open ? req : direction;

    always_comb begin
        nx    = pac_x;
        ny    = pac_y;
        mv_ok = 1'b0;
        if (req_open || dir_open) begin
            case (mv_dir)
                DIR_L: begin
                    if (pac_x != 10'd0) begin
                        nx    = pac_x - 10'd1;
                        mv_ok = 1'b1;
                    end
`ifdef PAC_TUNNEL_EN
                    else begin
                        nx    = XMAX_V;
                        mv_ok = 1'b1;
                    end
`endif
                end
                DIR_R: begin
                    if (pac_x < XMAX_V) begin
                        nx    = pac_x + 10'd1;
                        mv_ok = 1'b1;
                    end
`ifdef PAC_TUNNEL_EN
                    else begin
                        nx    = 10'd0;
                        mv_ok = 1'b1;
                    end
`endif
                end
                DIR_U: begin
                    if (pac_y != 10'd0) begin
                        ny    = pac_y - 10'd1;
                        mv_ok = 1'b1;
                    end
                end
                DIR_D: begin
                    if (pac_y < YMAX_V) begin
                        ny    = pac_y + 10'd1;
                        mv_ok = 1'b1;
                    end
                end
                default: mv_ok = 1'b0;
            endcase
        end
    end

    // Window test in 11 bits so pac_x+24 cannot wrap near the right edge
    assign x_end  = {1'b0, pac_x} + 11'd24;
    assign y_end  = {1'b0, pac_y} + 11'd24;
    assign in_win = (hcount >= pac_x) && ({1'b0, hcount} < x_end) &&
                    (vcount >= pac_y) && ({1'b0, vcount} < y_end);
    assign off_x  = hcount - pac_x;
    assign off_y  = vcount - pac_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            pac_x     <= XSTART_V;
            pac_y     <= YSTART_V;
            direction <= DIR_L;
            req       <= DIR_L;
            div       <= 4'd0;
            moving    <= 1'b0;
            spr_en    <= 1'b0;
            spr_x     <= 5'd0;
            spr_y     <= 5'd0;
        end else begin
            if (|btn)
                req <= btn_pri;
            if (frame_tick)
                div <= step ? 4'd0 : div + 4'd1;
            if (step) begin
                if (req_open)
                    direction <= req;
                if (mv_ok) begin
                    pac_x  <= nx;
                    pac_y  <= ny;
                    moving <= 1'b1;
                end else begin
                    moving <= 1'b0;
                end
            end
            spr_en <= in_win;
            spr_x  <= in_win ? off_x[4:0] : 5'd0;
            spr_y  <= in_win ? off_y[4:0] : 5'd0;
        end
    end

endmodule

// File: tb/tb_pac_ctrl.sv
// Scoreboard bench for pac_ctrl: directed scenarios plus random stimulus against a behavioural model.
module tb_pac_ctrl;
    localparam int X_START = 304;
    localparam int Y_START = 336;
    localparam int X_MAX   = 616;
    localparam int Y_MAX   = 456;
    localparam int SPEED   = 2;
`ifdef PAC_TUNNEL_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_l = 0, btn_u = 0, btn_r = 0, btn_d = 0;
    logic frame_tick = 0;
    logic blk_l = 0, blk_u = 0, blk_r = 0, blk_d = 0;
    logic [9:0] hcount = 0, vcount = 0;
    logic [9:0] pac_x, pac_y;
    logic [3:0] direction;
    logic [4:0] spr_x, spr_y;
    logic spr_en, moving;

    always #5 clk = ~clk;

    pac_ctrl #(.X_START(X_START), .Y_START(Y_START), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SPEED(SPEED)) dut (
        .clk(clk), .rst(rst),
        .btn_l(btn_l), .btn_u(btn_u), .btn_r(btn_r), .btn_d(btn_d),
        .frame_tick(frame_tick),
        .blk_l(blk_l), .blk_u(blk_u), .blk_r(blk_r), .blk_d(blk_d),
        .hcount(hcount), .vcount(vcount),
        .pac_x(pac_x), .pac_y(pac_y), .direction(direction),
        .spr_x(spr_x), .spr_y(spr_y), .spr_en(spr_en), .moving(moving)
    );

    typedef struct {
        int x;
        int y;
        int dir;
        int mv;
        int en;
        int sx;
        int sy;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;

    // model state: headings indexed 0=L 1=U 2=R 3=D
    int mx = X_START, my = Y_START, mdir = 0, mreq = 0, mtick = 0, mmov = 0;

    task automatic cmp(input string nm, input int act, input int req_v);
        checks++;
        if (act != req_v) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, req_v, $time);
        end
    endtask

    function automatic int onehot(input int i);
        return 8 >> i;
    endfunction

    task automatic model(input logic r, input logic [3:0] b, input logic f,
                         input logic [3:0] bk, input int h, input int v);
        exp_t e;
        int nx, ny, go;
        bit stepping, found;
        if (r) begin
            mx = X_START; my = Y_START; mdir = 0; mreq = 0; mtick = 0; mmov = 0;
            e.en = 0; e.sx = 0; e.sy = 0;
        end else begin
            e.en = (h >= mx && h < mx + 24 && v >= my && v < my + 24) ? 1 : 0;
            e.sx = e.en ? ((h - mx) % 32) : 0;
            e.sy = e.en ? ((v - my) % 32) : 0;
            stepping = 0;
            if (f) begin
                mtick++;
                if (mtick == SPEED) begin
                    mtick = 0;
                    stepping = 1;
                end
            end
            if (stepping) begin
                go = -1;
                if (!bk[3-mreq]) begin
                    mdir = mreq;
                    go = mreq;
                end else if (!bk[3-mdir]) begin
                    go = mdir;
                end
                mmov = 0;
                if (go >= 0) begin
                    nx = mx + ((go == 2) ? 1 : (go == 0) ? -1 : 0);
                    ny = my + ((go == 3) ? 1 : (go == 1) ? -1 : 0);
                    if (TUNNEL) begin
                        if (nx < 0) nx = X_MAX;
                        else if (nx > X_MAX) nx = 0;
                    end
                    if (nx >= 0 && nx <= X_MAX && ny >= 0 && ny <= Y_MAX) begin
                        mx = nx; my = ny; mmov = 1;
                    end
                end
            end
            found = 0;
            for (int i = 0; i < 4; i++)
                if (!found && b[3-i]) begin
                    mreq = i;
                    found = 1;
                end
        end
        e.x = mx; e.y = my; e.dir = onehot(mdir); e.mv = mmov;
        sb.push_back(e);
    endtask

    // One clock: apply inputs after the edge, predict the state after the next edge
    task automatic cyc(input logic r, input logic [3:0] b, input logic f, input logic [3:0] bk);
        int h, v;
        @(posedge clk);
        #2;
        if ($urandom_range(0, 7) == 0) begin
            h = $urandom_range(0, 1023);
            v = $urandom_range(0, 1023);
        end else begin
            h = mx + $urandom_range(0, 27) - 2;
            v = my + $urandom_range(0, 27) - 2;
            if (h < 0) h = 0;
            if (v < 0) v = 0;
        end
        rst = r;
        {btn_l, btn_u, btn_r, btn_d} = b;
        frame_tick = f;
        {blk_l, blk_u, blk_r, blk_d} = bk;
        hcount = 10'(h);
        vcount = 10'(v);
        model(r, b, f, bk, h, v);
    endtask

    task automatic walk_until(input bit use_x, input int target, input string nm);
        int n = 0;
        while (((use_x ? mx : my) != target) && n < 3000) begin
            cyc(0, 4'b0000, 1, 4'b0000);
            n++;
        end
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp(nm, use_x ? int'(pac_x) : int'(pac_y), target);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                cmp("sb_pac_x", pac_x, e.x);
                cmp("sb_pac_y", pac_y, e.y);
                cmp("sb_direction", direction, e.dir);
                cmp("sb_moving", moving, e.mv);
                cmp("sb_spr", {spr_en, spr_x, spr_y}, (e.en << 10) | (e.sx << 5) | e.sy);
            end
        end
    end

    initial begin : stim
        int n;
        cyc(1, 4'b0000, 0, 4'b0000);
        cyc(1, 4'b1111, 1, 4'b1111);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("rst_pac_x", pac_x, X_START);
        cmp("rst_pac_y", pac_y, Y_START);
        cmp("rst_dir", direction, 4'b1000);
        cmp("rst_moving", moving, 0);

        repeat (4) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("walk_pac_x", pac_x, 302);
        cmp("walk_pac_y", pac_y, 336);
        cmp("walk_dir", direction, 4'b1000);
        cmp("walk_moving", moving, 1);

        repeat (2) cyc(0, 4'b0000, 1, 4'b1000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("deadend_pac_x", pac_x, 302);
        cmp("deadend_moving", moving, 0);

        cyc(0, 4'b0100, 0, 4'b0100);
        repeat (2) cyc(0, 4'b0000, 1, 4'b0100);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("turnblk_pac_x", pac_x, 301);
        cmp("turnblk_dir", direction, 4'b1000);
        repeat (2) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("turnopen_dir", direction, 4'b0100);
        cmp("turnopen_pac_y", pac_y, 335);

        cyc(0, 4'b1111, 0, 4'b0000);
        repeat (2) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("prio_dir", direction, 4'b1000);
        cmp("prio_pac_x", pac_x, 300);

        n = 0;
        while (mtick != SPEED - 1 && n < 16) begin
            cyc(0, 4'b0000, 1, 4'b0000);
            n++;
        end
        cyc(1, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("rstmid_nostep", pac_x, X_START);
        cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("rstmid_step", pac_x, X_START - 1);

        walk_until(1, 0, "reach_x0");
        repeat (SPEED) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("tunnel_pac_x", pac_x, TUNNEL ? X_MAX : 0);
        cmp("tunnel_moving", moving, TUNNEL ? 1 : 0);

        cyc(0, 4'b0100, 0, 4'b0000);
        walk_until(0, 0, "reach_y0");
        repeat (SPEED) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("sat_y0_pac_y", pac_y, 0);
        cmp("sat_y0_moving", moving, 0);

        cyc(0, 4'b0010, 0, 4'b0000);
        walk_until(1, X_MAX, "reach_xmax");
        cyc(0, 4'b0001, 0, 4'b0000);
        walk_until(0, Y_MAX, "reach_ymax");
        repeat (SPEED) cyc(0, 4'b0000, 1, 4'b0000);
        cyc(0, 4'b0000, 0, 4'b0000);
        cmp("sat_ymax_pac_y", pac_y, Y_MAX);
        cmp("sat_ymax_moving", moving, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] b, bk;
            b  = ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'b0000;
            bk = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom());
            cyc(($urandom_range(0, 299) == 0), b, 1'($urandom_range(0, 1)), bk);
        end

        cyc(0, 4'b0000, 0, 4'b0000);
        @(posedge clk);
        #3;
        cmp("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
